snake_mover_param: RTL and testbench
====================================

Name: snake_mover_param

Overview:
Parametrised snake-body engine for the grid game. It holds the snake as a circular buffer of segment coordinates and advances it one cell per TICK in the requested direction. It handles growth, wall collision and self collision, and exposes a registered segment read port for the renderer. It sits between the input/direction decoder, the game-speed divider (TICK) and the VGA drawing logic.

Parameters:
GRID_W, 32, grid columns; legal X is 0..GRID_W-1
GRID_H, 24, grid rows; legal Y is 0..GRID_H-1
X_W, 5, X coordinate width
Y_W, 5, Y coordinate width
MAX_LEN, 64, buffer depth; must be a power of two
IDX_W, 6, log2(MAX_LEN)
INIT_LEN, 3, length after reset or RESTART; 1..MAX_LEN
START_X, 8, initial head X; must be >= INIT_LEN-1
START_Y, 12, initial head Y

Ports:
CLK  in  1  system clock
RST_N  in  1  reset; asynchronous, active-low
TICK  in  1  one-cycle move strobe
DIR_REQ  in  2  requested direction: 0=right, 1=up, 2=left, 3=down
DIR_VALID  in  1  DIR_REQ qualifier
GROW  in  1  one-cycle pulse from food logic; sets the grow-pending flag
RESTART  in  1  synchronous re-initialise
RD_IDX  in  IDX_W  segment index to read; 0 = head
RD_X  out  X_W  X of segment RD_IDX; registered, 1-cycle latency
RD_Y  out  Y_W  Y of segment RD_IDX; registered, 1-cycle latency
RD_VALID  out  1  registered (RD_IDX < LENGTH)
HEAD_X  out  X_W  current head X
HEAD_Y  out  Y_W  current head Y
LENGTH  out  IDX_W+1  current segment count
ALIVE  out  1  high until a collision
BUSY  out  1  high when not in IDLE
MOVED  out  1  one-cycle pulse when a move is committed
DIED  out  1  one-cycle pulse on entry to DEAD

Behaviour:
- Storage: MAX_LEN register array plus head pointer HP. Segment i is at entry (HP-i) mod MAX_LEN.
- Reset and RESTART state:
  - HP=0; segment i = (START_X-i, START_Y) for i < INIT_LEN; all other entries 0.
  - LENGTH=INIT_LEN, cur_dir=right, next_dir=right, grow_pend=0, ALIVE=1.
  - MOVED=0, DIED=0, RD_*=0, state=IDLE.
- RESTART is honoured in every state, including mid-scan and DEAD. It takes effect on the next edge and overrides TICK, GROW and DIR_VALID in the same cycle.
- Direction:
  - On DIR_VALID, next_dir<=DIR_REQ, unless DIR_REQ is the opposite of cur_dir (a reversal), in which case it is ignored.
  - cur_dir<=next_dir only at COMMIT.
  - The last valid request before TICK wins.
- Grow: a GROW pulse in any state sets grow_pend. grow_pend is cleared at a COMMIT that consumed it.
- FSM states: IDLE, CHECK, COMMIT, DEAD.
- IDLE:
  - TICK: compute candidate head C = head + step(next_dir); latch g = grow_pend and (LENGTH < MAX_LEN).
  - If C is outside the grid (X = -1 or GRID_W, Y = -1 or GRID_H, evaluated in X_W+1 / Y_W+1 bits), go to DEAD.
  - Otherwise idx<=0 and go to CHECK.
- CHECK:
  - Compare one segment per cycle, segment idx against C.
  - Scan limit N = LENGTH if g, else LENGTH-1 (the tail vacates, so moving into the tail cell is legal).
  - Match: go to DEAD.
  - Otherwise, when idx = N-1 or N = 0, go to COMMIT; else idx+1.
- COMMIT:
  - HP<=HP+1 and write C at the new HP.
  - If g, LENGTH+1 and clear grow_pend.
  - Assert MOVED for one cycle; return to IDLE.
- Move latency: TICK to MOVED = N+2 cycles.
- DEAD: ALIVE=0; DIED pulses on entry; TICK is ignored; only RESTART or reset exits.
- TICK outside IDLE is dropped, not queued.
- LENGTH saturates at MAX_LEN: the snake moves with the tail discarded and grow_pend is kept.
- Read port: the RD_IDX index is also mod MAX_LEN. During COMMIT, RD_* reflect the pre-commit buffer.

Optional Feature:
Macro SNAKE_WRAP_EN.
- Defined: crossing a wall wraps the coordinate (X -1 becomes GRID_W-1, X GRID_W becomes 0, same for Y). There is no wall death; only self collision kills.
- Undefined: a wall crossing goes IDLE to DEAD as specified above.

Test Plan:
- Reset with defaults, then 1 TICK -> head (9,12), MOVED exactly 4 cycles after TICK (N=2), LENGTH=3, segments (9,12),(8,12),(7,12).
- Head right, DIR_REQ=left with DIR_VALID, then TICK -> reversal ignored, head X+1. Then DIR_REQ=up, TICK -> Y-1.
- GROW pulse, then TICK -> LENGTH=4, old tail kept. At MAX_LEN=4 with GROW, TICK -> LENGTH stays 4, grow_pend stays 1.
- Head at X=31 facing right, TICK -> DIED pulse, ALIVE=0, later TICKs ignored. With SNAKE_WRAP_EN, head becomes (0,Y) instead.
- Length-5 snake turned down, left, up into its own body -> DIED. Length-4 ring move into tail cell without grow -> legal, MOVED.
- RESTART asserted mid-CHECK -> next cycle state IDLE, LENGTH=3, head (8,12), ALIVE=1, no MOVED or DIED.

Source files
------------

// File: rtl/snake_mover_param_if.sv
// Bundle between the snake engine and its surrounding game logic: move/direction/grow
// controls plus the registered segment read port and status outputs.
interface snake_mover_param_if #(
  parameter int X_W   = 5,
  parameter int Y_W   = 5,
  parameter int IDX_W = 6
);
  logic             TICK;
  logic [1:0]       DIR_REQ;
  logic             DIR_VALID;
  logic             GROW;
  logic             RESTART;
  logic [IDX_W-1:0] RD_IDX;
  logic [X_W-1:0]   RD_X;
  logic [Y_W-1:0]   RD_Y;
  logic             RD_VALID;
  logic [X_W-1:0]   HEAD_X;
  logic [Y_W-1:0]   HEAD_Y;
  logic [IDX_W:0]   LENGTH;
  logic             ALIVE;
  logic             BUSY;
  logic             MOVED;
  logic             DIED;

  modport master (
    output TICK, DIR_REQ, DIR_VALID, GROW, RESTART, RD_IDX,
    input  RD_X, RD_Y, RD_VALID, HEAD_X, HEAD_Y, LENGTH, ALIVE, BUSY, MOVED, DIED
  );

  modport slave (
    input  TICK, DIR_REQ, DIR_VALID, GROW, RESTART, RD_IDX,
    output RD_X, RD_Y, RD_VALID, HEAD_X, HEAD_Y, LENGTH, ALIVE, BUSY, MOVED, DIED
  );
endinterface

// File: rtl/snake_mover_param.sv
// Snake body engine: circular buffer of segment coordinates, one cell per TICK,
// growth, wall and self collision, registered segment read port.
// Optional macro SNAKE_WRAP_EN: walls wrap around instead of killing the snake.
module snake_mover_param #(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int X_W      = 5,
  parameter int Y_W      = 5,
  parameter int MAX_LEN  = 64,
  parameter int IDX_W    = 6,
  parameter int INIT_LEN = 3,
  parameter int START_X  = 8,
  parameter int START_Y  = 12
) (
  input logic               CLK,
  input logic               RST_N,
  snake_mover_param_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CHECK, COMMIT, DEAD} state_t;
  typedef enum logic [1:0] {RIGHT = 2'd0, UP = 2'd1, LEFT = 2'd2, DOWN = 2'd3} dir_t;

  localparam logic [IDX_W:0] MAX_LEN_V  = (IDX_W+1)'(MAX_LEN);
  localparam logic [IDX_W:0] INIT_LEN_V = (IDX_W+1)'(INIT_LEN);
  localparam logic [X_W:0]   X_HI       = (X_W+1)'(GRID_W);
  localparam logic [Y_W:0]   Y_HI       = (Y_W+1)'(GRID_H);

  state_t           state, next_state;
  dir_t             cur_dir, next_dir, mv_dir;
  logic [X_W-1:0]   mem_x [MAX_LEN];
  logic [Y_W-1:0]   mem_y [MAX_LEN];
  logic [IDX_W-1:0] hp, idx, seg_ptr, rd_ptr;
  logic [IDX_W:0]   length, scan_n;
  logic             grow_pend, g;
  logic [X_W-1:0]   cand_x, c_x, head_x, rd_x;
  logic [Y_W-1:0]   cand_y, c_y, head_y, rd_y;
  logic [X_W:0]     step_x;
  logic [Y_W:0]     step_y;
  logic             wall, hit, last, moved, died, rd_valid;

  assign head_x  = mem_x[hp];
  assign head_y  = mem_y[hp];
  assign seg_ptr = hp - idx;
  assign rd_ptr  = hp - bus.RD_IDX;
  assign scan_n  = g ? length : length - 1'b1;
  assign hit     = (scan_n != '0) && (mem_x[seg_ptr] == cand_x) && (mem_y[seg_ptr] == cand_y);
  assign last    = (scan_n == '0) || ({1'b0, idx} == scan_n - 1'b1);

  assign bus.RD_X     = rd_x;
  assign bus.RD_Y     = rd_y;
  assign bus.RD_VALID = rd_valid;
  assign bus.HEAD_X   = head_x;
  assign bus.HEAD_Y   = head_y;
  assign bus.LENGTH   = length;
  assign bus.ALIVE    = (state != DEAD);
  assign bus.BUSY     = (state != IDLE);
  assign bus.MOVED    = moved;
  assign bus.DIED     = died;

  // Candidate head one step along next_dir, one extra bit so -1 and GRID are visible.
  always_comb begin
    step_x = {1'b0, head_x};
    step_y = {1'b0, head_y};
    unique case (next_dir)
      RIGHT: step_x = {1'b0, head_x} + 1'b1;
      UP:    step_y = {1'b0, head_y} - 1'b1;
      LEFT:  step_x = {1'b0, head_x} - 1'b1;
      DOWN:  step_y = {1'b0, head_y} + 1'b1;
    endcase
`ifdef SNAKE_WRAP_EN
    c_x  = (step_x == '1) ? X_W'(GRID_W - 1) : (step_x == X_HI) ? '0 : step_x[X_W-1:0];
    c_y  = (step_y == '1) ? Y_W'(GRID_H - 1) : (step_y == Y_HI) ? '0 : step_y[Y_W-1:0];
    wall = 1'b0;
`else
    c_x  = step_x[X_W-1:0];
    c_y  = step_y[Y_W-1:0];
    wall = (step_x == '1) || (step_x == X_HI) || (step_y == '1) || (step_y == Y_HI);
`endif
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic; RESTART takes priority from every state.
  always_comb begin
    next_state = state;
    if (bus.RESTART) begin
      next_state = IDLE;
    end else begin
      unique case (state)
        IDLE:   if (bus.TICK) next_state = wall ? DEAD : CHECK;
        CHECK:  if (hit) next_state = DEAD;
                else if (last) next_state = COMMIT;
        COMMIT: next_state = IDLE;
        DEAD:   next_state = DEAD;
      endcase
    end
  end

  // Segment buffer, direction, growth, scan counter, pulses and read port.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        mem_x[IDX_W'(i)] <= '0;
        mem_y[IDX_W'(i)] <= '0;
      end
      for (int unsigned i = 0; i < INIT_LEN; i++) begin
        mem_x[IDX_W'(MAX_LEN - i)] <= X_W'(START_X - i);
        mem_y[IDX_W'(MAX_LEN - i)] <= Y_W'(START_Y);
      end
      hp        <= '0;
      idx       <= '0;
      length    <= INIT_LEN_V;
      cur_dir   <= RIGHT;
      next_dir  <= RIGHT;
      mv_dir    <= RIGHT;
      grow_pend <= 1'b0;
      g         <= 1'b0;
      cand_x    <= '0;
      cand_y    <= '0;
      moved     <= 1'b0;
      died      <= 1'b0;
      rd_x      <= '0;
      rd_y      <= '0;
      rd_valid  <= 1'b0;
    end else if (bus.RESTART) begin
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
        mem_x[IDX_W'(i)] <= '0;
        mem_y[IDX_W'(i)] <= '0;
      end
      for (int unsigned i = 0; i < INIT_LEN; i++) begin
        mem_x[IDX_W'(MAX_LEN - i)] <= X_W'(START_X - i);
        mem_y[IDX_W'(MAX_LEN - i)] <= Y_W'(START_Y);
      end
      hp        <= '0;
      idx       <= '0;
      length    <= INIT_LEN_V;
      cur_dir   <= RIGHT;
      next_dir  <= RIGHT;
      mv_dir    <= RIGHT;
      grow_pend <= 1'b0;
      g         <= 1'b0;
      cand_x    <= '0;
      cand_y    <= '0;
      moved     <= 1'b0;
      died      <= 1'b0;
      rd_x      <= '0;
      rd_y      <= '0;
      rd_valid  <= 1'b0;
    end else begin
      moved    <= (state == COMMIT);
      died     <= (next_state == DEAD) && (state != DEAD);
      rd_x     <= mem_x[rd_ptr];
      rd_y     <= mem_y[rd_ptr];
      rd_valid <= ({1'b0, bus.RD_IDX} < length);
      if (bus.DIR_VALID && (bus.DIR_REQ != (cur_dir ^ 2'b10)))
        next_dir <= dir_t'(bus.DIR_REQ);
      if (bus.GROW)
        grow_pend <= 1'b1;
      else if ((state == COMMIT) && g)
        grow_pend <= 1'b0;
      unique case (state)
        IDLE: if (bus.TICK) begin
          cand_x <= c_x;
          cand_y <= c_y;
          g      <= grow_pend && (length < MAX_LEN_V);
          idx    <= '0;
          // Direction actually taken by this move; requests arriving mid-scan
          // only affect later moves and cannot turn cur_dir into a reversal.
          mv_dir <= next_dir;
        end
        CHECK: idx <= idx + 1'b1;
        COMMIT: begin
          hp                   <= hp + 1'b1;
          mem_x[hp + 1'b1]     <= cand_x;
          mem_y[hp + 1'b1]     <= cand_y;
          cur_dir              <= mv_dir;
          if (g) length        <= length + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_mover_param.sv
// Scoreboard bench for snake_mover_param: expected move/death events are queued when
// TICK is driven and checked when MOVED or DIED fires.
module tb_snake_mover_param;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  snake_mover_param_if #(.X_W(5), .Y_W(5), .IDX_W(6)) mbus ();
  snake_mover_param_if #(.X_W(5), .Y_W(5), .IDX_W(2)) sbus ();

  snake_mover_param u_dut (.CLK(CLK), .RST_N(RST_N), .bus(mbus));
  snake_mover_param #(.MAX_LEN(4), .IDX_W(2)) u_small (.CLK(CLK), .RST_N(RST_N), .bus(sbus));

  typedef struct {
    bit die;
    int x;
    int y;
    int len;
    int lat;
    int t0;
  } sb_t;

  sb_t sb_q[$];
  sb_t mon_e;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pops one expectation per MOVED/DIED pulse of the main instance.
  always @(negedge CLK) begin
    if (RST_N && (mbus.MOVED || mbus.DIED)) begin
      if (sb_q.size() == 0) begin
        check("unexpected_event", int'({mbus.MOVED, mbus.DIED}), 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("event_died", int'(mbus.DIED), int'(mon_e.die));
        check("event_latency", cyc - mon_e.t0, mon_e.lat);
        check("event_alive", int'(mbus.ALIVE), mon_e.die ? 0 : 1);
        if (!mon_e.die) begin
          check("move_head_x", int'(mbus.HEAD_X), mon_e.x);
          check("move_head_y", int'(mbus.HEAD_Y), mon_e.y);
          check("move_length", int'(mbus.LENGTH), mon_e.len);
        end
      end
    end
  end

  task automatic wait_drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge CLK);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      check("event_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
  endtask

  task automatic tick(input int ex, input int ey, input int elen, input int elat, input bit die);
    sb_t e;
    @(negedge CLK);
    e.die = die; e.x = ex; e.y = ey; e.len = elen; e.lat = elat; e.t0 = cyc;
    sb_q.push_back(e);
    mbus.TICK = 1'b1;
    @(negedge CLK);
    mbus.TICK = 1'b0;
    wait_drain();
  endtask

  task automatic set_dir(input logic [1:0] d);
    @(negedge CLK);
    mbus.DIR_REQ   = d;
    mbus.DIR_VALID = 1'b1;
    @(negedge CLK);
    mbus.DIR_VALID = 1'b0;
  endtask

  task automatic pulse_grow();
    @(negedge CLK);
    mbus.GROW = 1'b1;
    @(negedge CLK);
    mbus.GROW = 1'b0;
  endtask

  task automatic do_restart();
    @(negedge CLK);
    mbus.RESTART = 1'b1;
    @(negedge CLK);
    mbus.RESTART = 1'b0;
  endtask

  task automatic read_seg(input int i, input int ex, input int ey, input int ev);
    @(negedge CLK);
    mbus.RD_IDX = 6'(i);
    @(negedge CLK);
    check($sformatf("seg%0d_x", i), int'(mbus.RD_X), ex);
    check($sformatf("seg%0d_y", i), int'(mbus.RD_Y), ey);
    check($sformatf("seg%0d_valid", i), int'(mbus.RD_VALID), ev);
  endtask

  task automatic check_restart_state(input string tag);
    check({tag, "_head_x"}, int'(mbus.HEAD_X), 8);
    check({tag, "_head_y"}, int'(mbus.HEAD_Y), 12);
    check({tag, "_length"}, int'(mbus.LENGTH), 3);
    check({tag, "_alive"}, int'(mbus.ALIVE), 1);
    check({tag, "_busy"}, int'(mbus.BUSY), 0);
  endtask

  // TICK in DEAD must be dropped; the monitor flags any event that shows up.
  task automatic dead_tick();
    @(negedge CLK);
    mbus.TICK = 1'b1;
    @(negedge CLK);
    mbus.TICK = 1'b0;
    repeat (8) @(negedge CLK);
    check("dead_alive", int'(mbus.ALIVE), 0);
    check("dead_busy", int'(mbus.BUSY), 1);
  endtask

  task automatic small_move(input int ex, input int ey, input bit grow);
    int t0;
    int n;
    if (grow) begin
      @(negedge CLK);
      sbus.GROW = 1'b1;
      @(negedge CLK);
      sbus.GROW = 1'b0;
    end
    @(negedge CLK);
    sbus.TICK = 1'b1;
    t0 = cyc;
    @(negedge CLK);
    sbus.TICK = 1'b0;
    n = 0;
    while (!sbus.MOVED && n < 50) begin
      @(negedge CLK);
      n++;
    end
    check("small_latency", cyc - t0, 5);
    check("small_head_x", int'(sbus.HEAD_X), ex);
    check("small_head_y", int'(sbus.HEAD_Y), ey);
    check("small_length", int'(sbus.LENGTH), 4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mbus.TICK = 1'b0; mbus.DIR_REQ = 2'd0; mbus.DIR_VALID = 1'b0;
    mbus.GROW = 1'b0; mbus.RESTART = 1'b0; mbus.RD_IDX = '0;
    sbus.TICK = 1'b0; sbus.DIR_REQ = 2'd0; sbus.DIR_VALID = 1'b0;
    sbus.GROW = 1'b0; sbus.RESTART = 1'b0; sbus.RD_IDX = '0;

    repeat (3) @(negedge CLK);
    check("reset_rd_x", int'(mbus.RD_X), 0);
    check("reset_rd_valid", int'(mbus.RD_VALID), 0);
    check("reset_moved", int'(mbus.MOVED), 0);
    check("reset_died", int'(mbus.DIED), 0);
    RST_N = 1'b1;
    check_restart_state("reset");

    read_seg(0, 8, 12, 1);
    read_seg(1, 7, 12, 1);
    read_seg(2, 6, 12, 1);
    read_seg(3, 0, 0, 0);
    read_seg(63, 0, 0, 0);

    // First move right, N = 2.
    tick(9, 12, 3, 4, 1'b0);
    read_seg(0, 9, 12, 1);
    read_seg(2, 7, 12, 1);

    // Reversal ignored, then turn up.
    set_dir(2'd2);
    tick(10, 12, 3, 4, 1'b0);
    set_dir(2'd1);
    tick(10, 11, 3, 4, 1'b0);

    // Growth keeps the old tail.
    pulse_grow();
    tick(10, 10, 4, 5, 1'b0);
    read_seg(3, 9, 12, 1);
    pulse_grow();
    tick(10, 9, 5, 6, 1'b0);

    // Curl back into the body: right, down, left hits segment 3.
    set_dir(2'd0);
    tick(11, 9, 5, 6, 1'b0);
    set_dir(2'd3);
    tick(11, 10, 5, 6, 1'b0);
    set_dir(2'd2);
    tick(0, 0, 0, 5, 1'b1);
    check("self_hit_head_x", int'(mbus.HEAD_X), 11);
    check("self_hit_head_y", int'(mbus.HEAD_Y), 10);
    check("self_hit_length", int'(mbus.LENGTH), 5);
    dead_tick();

    do_restart();
    check_restart_state("restart_dead");

    // Run to the right wall.
    for (int x = 9; x <= 31; x++) tick(x, 12, 3, 4, 1'b0);
`ifdef SNAKE_WRAP_EN
    tick(0, 12, 3, 4, 1'b0);
`else
    tick(0, 0, 0, 1, 1'b1);
    check("wall_head_x", int'(mbus.HEAD_X), 31);
    dead_tick();
`endif

    do_restart();
    check_restart_state("restart_wall");

    // RESTART while scanning.
    tick(9, 12, 3, 4, 1'b0);
    @(negedge CLK);
    mbus.TICK = 1'b1;
    @(negedge CLK);
    mbus.TICK = 1'b0;
    check("mid_check_busy", int'(mbus.BUSY), 1);
    mbus.RESTART = 1'b1;
    @(negedge CLK);
    mbus.RESTART = 1'b0;
    check_restart_state("restart_mid_check");
    check("restart_mid_check_moved", int'(mbus.MOVED), 0);
    check("restart_mid_check_died", int'(mbus.DIED), 0);
    repeat (8) @(negedge CLK);

    // Length-4 ring: stepping into the vacating tail is legal.
    pulse_grow();
    tick(9, 12, 4, 5, 1'b0);
    set_dir(2'd1);
    tick(9, 11, 4, 5, 1'b0);
    set_dir(2'd2);
    tick(8, 11, 4, 5, 1'b0);
    set_dir(2'd3);
    tick(8, 12, 4, 5, 1'b0);
    read_seg(3, 9, 12, 1);

    // Saturation on the MAX_LEN = 4 instance.
    small_move(9, 12, 1'b1);
    small_move(10, 12, 1'b1);
    check("small_grow_pend_kept", int'(u_small.grow_pend), 1);
    small_move(11, 12, 1'b0);
    check("small_grow_pend_still", int'(u_small.grow_pend), 1);

    repeat (4) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
